pred_pht: RTL

PRED_PHT -- requirements
Module: pred_pht

---
 rtl/pred_def.sv | 20 ++
 rtl/pred_sat_ctr.sv | 22 ++
 rtl/pred_pht.sv | 83 ++++++++
 3 files changed

// File: rtl/pred_def.sv
// Shared definitions for the pattern-history-table predictor: counter
// encodings and the reset-value formula used by every counter width.
package pred_def;

  localparam int CTR_W_MAX = 4;

  // Two-bit counter meaning; wider counters keep the MSB-is-taken rule.
  typedef enum logic [1:0] {
    CTR_SNT = 2'd0,
    CTR_WNT = 2'd1,
    CTR_WT  = 2'd2,
    CTR_ST  = 2'd3
  } ctr2_state_e;

  // Weakly not-taken: the largest value whose MSB is still clear.
  function automatic logic [CTR_W_MAX-1:0] ctr_reset_val(input int ctr_w);
    return CTR_W_MAX'((1 << (ctr_w - 1)) - 1);
  endfunction

endpackage

// File: rtl/pred_sat_ctr.sv
// Saturating up/down next-value logic for one prediction counter.
module pred_sat_ctr #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] cur,
  input  logic             taken,
  output logic [CTR_W-1:0] nxt
);

  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  always_comb begin
    // NOTE: default first so every path assigns nxt and no latch is inferred.
    nxt = cur;
    if (taken) begin
      if (cur != CTR_MAX) nxt = cur + CTR_W'(1);
    end else if (cur != '0) begin
      nxt = cur - CTR_W'(1);
    end
  end

endmodule

// File: rtl/pred_pht.sv
// Pattern history table of saturating counters with bimodal or gshare
// indexing, one-cycle registered lookup and same-cycle update bypass.
module pred_pht
  import pred_def::*;
#(
  parameter int INDEX_W   = 6,
  parameter int CTR_W     = 2,
  parameter int HASH_MODE = 0
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               pred_valid,
  input  logic [31:0]        pred_pc,
  output logic               pred_resp_valid,
  output logic               pred_taken,
  output logic [INDEX_W-1:0] pred_index,
  input  logic               upd_valid,
  input  logic [INDEX_W-1:0] upd_index,
  input  logic               upd_taken
);

  localparam int               ENTRIES = 1 << INDEX_W;
  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(ctr_reset_val(CTR_W));

  logic [CTR_W-1:0]   ctr_q [ENTRIES];
  logic [INDEX_W-1:0] ghr_q;
  logic [INDEX_W-1:0] lookup_idx;
  logic [CTR_W-1:0]   upd_cur;
  logic [CTR_W-1:0]   upd_nxt;
  logic [CTR_W-1:0]   lookup_ctr;
  logic               unused_pc_bits;

  assign unused_pc_bits = ^{pred_pc[31:INDEX_W+2], pred_pc[1:0]};

  // ghr_q here is the pre-update history, so a same-cycle update never
  // perturbs the index being looked up.
  assign lookup_idx = pred_pc[INDEX_W+1:2] ^ ((HASH_MODE == 1) ? ghr_q : '0);

  assign upd_cur = ctr_q[upd_index];

  pred_sat_ctr #(.CTR_W(CTR_W)) u_sat_ctr (
    .cur   (upd_cur),
    .taken (upd_taken),
    .nxt   (upd_nxt)
  );

  assign lookup_ctr = (upd_valid && (upd_index == lookup_idx)) ? upd_nxt
                                                               : ctr_q[lookup_idx];

  // NOTE: the table is a flop array, not a RAM, so every entry can take the
  // asynchronous reset value; a RAM would need a sequenced clear instead.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_RST;
    end else if (upd_valid) begin
      ctr_q[upd_index] <= upd_nxt;
    end
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ghr_q <= '0;
    end else if (upd_valid) begin
      ghr_q <= {ghr_q[INDEX_W-2:0], upd_taken};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pred_resp_valid <= 1'b0;
      pred_taken      <= 1'b0;
      pred_index      <= '0;
    end else begin
      pred_resp_valid <= pred_valid;
      if (pred_valid) begin
        pred_taken <= lookup_ctr[CTR_W-1];
        pred_index <= lookup_idx;
      end
    end
  end

endmodule
